// File: rtl/dump_gate_driver.sv
// Dead-time protected ON/OFF gate driver for the transmitter-coil energy dump.
// Define DUMP_INPUT_SYNC_EN to pass dumpon_str, dumpoff_str and over through 2-flop synchronizers.
module dump_gate_driver #(
  parameter int DEAD_CYC = 4,
  parameter int MAX_ON   = 1000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       dumpon_str,
  input  logic       dumpoff_str,
  input  logic       over,
  input  logic       clr_fault,
  output logic       dump_on_gate,
  output logic       dump_off_gate,
  output logic       fault,
  output logic [7:0] pulse_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DT_ON,
    ON,
    DT_OFF,
    OFF,
    FAULT
  } state_t;

  localparam logic [7:0]  DEAD_LOAD = 8'(DEAD_CYC - 1);
  localparam logic [15:0] ON_LAST   = 16'(MAX_ON - 1);

  logic on_s;
  logic off_s;
  logic over_s;

`ifdef DUMP_INPUT_SYNC_EN
  logic [1:0] on_sync;
  logic [1:0] off_sync;
  logic [1:0] over_sync;

  always_ff @(posedge clkin) begin
    if (reset) begin
      on_sync   <= 2'b00;
      off_sync  <= 2'b00;
      over_sync <= 2'b00;
    end else begin
      on_sync   <= {on_sync[0], dumpon_str};
      off_sync  <= {off_sync[0], dumpoff_str};
      over_sync <= {over_sync[0], over};
    end
  end

  assign on_s   = on_sync[1];
  assign off_s  = off_sync[1];
  assign over_s = over_sync[1];
`else
  assign on_s   = dumpon_str;
  assign off_s  = dumpoff_str;
  assign over_s = over;
`endif

  logic req_on;
  logic req_off;
  logic req_bad;
  logic req_idle;

  assign req_on   = over_s & on_s & ~off_s;
  assign req_off  = over_s & off_s & ~on_s;
  assign req_bad  = over_s & on_s & off_s;
  assign req_idle = ~(req_on | req_off | req_bad);

  state_t      state;
  logic [7:0]  dead_cnt;
  logic [15:0] on_timer;

  // Gate/fault outputs default low each edge and are raised only on paths landing in
  // ON, OFF or FAULT, so they always equal the decode of the state being entered.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state         <= IDLE;
      dead_cnt      <= 8'd0;
      on_timer      <= 16'd0;
      pulse_cnt     <= 8'd0;
      dump_on_gate  <= 1'b0;
      dump_off_gate <= 1'b0;
      fault         <= 1'b0;
    end else begin
      dump_on_gate  <= 1'b0;
      dump_off_gate <= 1'b0;
      fault         <= 1'b0;
      case (state)
        IDLE: begin
          if (req_bad) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (req_on) begin
            state    <= DT_ON;
            dead_cnt <= DEAD_LOAD;
          end else if (req_off) begin
            state    <= DT_OFF;
            dead_cnt <= DEAD_LOAD;
          end
        end
        DT_ON: begin
          if (req_bad) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (req_on) begin
            if (dead_cnt == 8'd0) begin
              state        <= ON;
              dump_on_gate <= 1'b1;
              on_timer     <= 16'd0;
              if (pulse_cnt != 8'hFF) pulse_cnt <= pulse_cnt + 8'd1;
            end else begin
              dead_cnt <= dead_cnt - 8'd1;
            end
          end else if (req_off) begin
            state    <= DT_OFF;
            dead_cnt <= DEAD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        ON: begin
          if (req_bad) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (req_on) begin
            if (on_timer == ON_LAST) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              on_timer     <= on_timer + 16'd1;
              dump_on_gate <= 1'b1;
            end
          end else if (req_off) begin
            state    <= DT_OFF;
            dead_cnt <= DEAD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        DT_OFF: begin
          if (req_bad) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (req_off) begin
            if (dead_cnt == 8'd0) begin
              state         <= OFF;
              dump_off_gate <= 1'b1;
            end else begin
              dead_cnt <= dead_cnt - 8'd1;
            end
          end else if (req_on) begin
            state    <= DT_ON;
            dead_cnt <= DEAD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        OFF: begin
          if (req_bad) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (req_on) begin
            state    <= DT_ON;
            dead_cnt <= DEAD_LOAD;
          end else if (req_off) begin
            dump_off_gate <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        FAULT: begin
          if (clr_fault && req_idle) begin
            state <= IDLE;
          end else begin
            fault <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dump_gate_driver.sv
// Self-checking bench for dump_gate_driver: directed scenarios plus randomized bursts,
// all compared cycle by cycle against a run-length reference model.
module tb_dump_gate_driver;

  localparam int DEAD  = 4;
  localparam int MAXON = 20;
`ifdef DUMP_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       dumpon_str = 1'b0;
  logic       dumpoff_str = 1'b0;
  logic       over = 1'b0;
  logic       clr_fault = 1'b0;
  logic       dump_on_gate;
  logic       dump_off_gate;
  logic       fault;
  logic [7:0] pulse_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: length of the current uninterrupted ON/OFF request run.
  int run_on = 0;
  int run_off = 0;
  int m_cnt = 0;
  bit m_on = 1'b0;
  bit m_off = 1'b0;
  bit m_fault = 1'b0;
`ifdef DUMP_INPUT_SYNC_EN
  bit [1:0] d_on = 2'b00;
  bit [1:0] d_off = 2'b00;
  bit [1:0] d_ov = 2'b00;
`endif

  dump_gate_driver #(
    .DEAD_CYC(DEAD),
    .MAX_ON  (MAXON)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .dumpon_str   (dumpon_str),
    .dumpoff_str  (dumpoff_str),
    .over         (over),
    .clr_fault    (clr_fault),
    .dump_on_gate (dump_on_gate),
    .dump_off_gate(dump_off_gate),
    .fault        (fault),
    .pulse_cnt    (pulse_cnt)
  );

  always #5 clkin = ~clkin;

  // A gate is high once its request has held for DEAD+1 edges, until the run exceeds
  // DEAD+MAX_ON (watchdog fault); conflicting strobes fault immediately.
  task automatic model_step();
    bit s_on, s_off, s_ov, r_on, r_off, r_bad, r_idle;
`ifdef DUMP_INPUT_SYNC_EN
    s_on  = d_on[1];
    s_off = d_off[1];
    s_ov  = d_ov[1];
    if (reset) begin
      d_on = 2'b00; d_off = 2'b00; d_ov = 2'b00;
    end else begin
      d_on  = {d_on[0], dumpon_str};
      d_off = {d_off[0], dumpoff_str};
      d_ov  = {d_ov[0], over};
    end
`else
    s_on  = dumpon_str;
    s_off = dumpoff_str;
    s_ov  = over;
`endif
    if (reset) begin
      run_on = 0; run_off = 0; m_cnt = 0;
      m_on = 1'b0; m_off = 1'b0; m_fault = 1'b0;
      return;
    end
    r_on   = s_ov && s_on && !s_off;
    r_off  = s_ov && s_off && !s_on;
    r_bad  = s_ov && s_on && s_off;
    r_idle = !(r_on || r_off || r_bad);
    if (m_fault) begin
      if (clr_fault && r_idle) m_fault = 1'b0;
      run_on = 0; run_off = 0;
    end else if (r_bad) begin
      m_fault = 1'b1; run_on = 0; run_off = 0;
    end else begin
      run_on  = r_on ? run_on + 1 : 0;
      run_off = r_off ? run_off + 1 : 0;
      if (run_on == DEAD + 1 + MAXON) begin
        m_fault = 1'b1; run_on = 0;
      end else if (run_on == DEAD + 1 && m_cnt < 255) begin
        m_cnt = m_cnt + 1;
      end
    end
    m_on  = !m_fault && run_on >= DEAD + 1;
    m_off = !m_fault && run_off >= DEAD + 1;
  endtask

  task automatic drive(input bit on_v, input bit off_v, input bit ov_v, input bit clr_v);
    dumpon_str  = on_v;
    dumpoff_str = off_v;
    over        = ov_v;
    clr_fault   = clr_v;
    @(posedge clkin);
    model_step();
    cyc++;
    #1;
  endtask

  function automatic bit lockstep_ok();
    return ({dump_on_gate, dump_off_gate, fault, pulse_cnt} ===
            {m_on, m_off, m_fault, m_cnt[7:0]}) && !(dump_on_gate && dump_off_gate);
  endfunction

  function automatic string got_s();
    return $sformatf("on=%b off=%b fault=%b cnt=%0d", dump_on_gate, dump_off_gate, fault, pulse_cnt);
  endfunction

  function automatic string want_s();
    return $sformatf("on=%b off=%b fault=%b cnt=%0d", m_on, m_off, m_fault, m_cnt);
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({dump_on_gate, dump_off_gate, fault, pulse_cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got %s want all zero", got_s());
    end
  endtask

  task automatic test_dead_time();
    int first_on = -1;
    for (int i = 1; i <= DEAD + SYNC_LAT + 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (!lockstep_ok()) begin
        failures++;
        $display("[TB] FAIL dead_time_lockstep cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
      if (dump_on_gate === 1'b1 && first_on < 0) first_on = i;
    end
    checks++;
    if (first_on !== DEAD + 1 + SYNC_LAT) begin
      failures++;
      $display("[TB] FAIL dead_time_latency got %0d want %0d", first_on, DEAD + 1 + SYNC_LAT);
    end
    checks++;
    if (pulse_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL first_pulse_cnt got %0d want 1", pulse_cnt);
    end
  endtask

  task automatic test_switchover();
    int on_low = -1;
    int off_high = -1;
    for (int i = 1; i <= DEAD + SYNC_LAT + 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (!lockstep_ok()) begin
        failures++;
        $display("[TB] FAIL switchover_lockstep cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
      if (dump_on_gate === 1'b0 && on_low < 0) on_low = i;
      if (dump_off_gate === 1'b1 && off_high < 0) off_high = i;
    end
    checks++;
    if (on_low !== 1 + SYNC_LAT || off_high !== DEAD + 1 + SYNC_LAT) begin
      failures++;
      $display("[TB] FAIL switchover_latency got on_low=%0d off_high=%0d want %0d %0d",
               on_low, off_high, 1 + SYNC_LAT, DEAD + 1 + SYNC_LAT);
    end
  endtask

  task automatic test_fault_clear();
    int first_fault = -1;
    for (int i = 1; i <= SYNC_LAT + 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (!lockstep_ok()) begin
        failures++;
        $display("[TB] FAIL bad_req_lockstep cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
      if (fault === 1'b1 && first_fault < 0) first_fault = i;
    end
    checks++;
    if (first_fault !== 1 + SYNC_LAT) begin
      failures++;
      $display("[TB] FAIL bad_req_latency got %0d want %0d", first_fault, 1 + SYNC_LAT);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (fault !== 1'b1 || dump_on_gate !== 1'b0 || dump_off_gate !== 1'b0) begin
        failures++;
        $display("[TB] FAIL fault_hold_with_strobe got %s want fault=1 gates=0", got_s());
      end
    end
    for (int i = 0; i < SYNC_LAT + 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (fault !== 1'b0 || !lockstep_ok()) begin
      failures++;
      $display("[TB] FAIL fault_clear got %s want %s", got_s(), want_s());
    end
  endtask

  task automatic test_watchdog();
    int high_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (!lockstep_ok()) begin
        failures++;
        $display("[TB] FAIL watchdog_lockstep cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
      if (dump_on_gate === 1'b1) high_cycles++;
    end
    checks++;
    if (high_cycles !== MAXON || fault !== 1'b1 || dump_on_gate !== 1'b0 || dump_off_gate !== 1'b0) begin
      failures++;
      $display("[TB] FAIL watchdog got high=%0d %s want high=%0d fault=1", high_cycles, got_s(), MAXON);
    end
    for (int i = 0; i < SYNC_LAT + 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_on();
    int first_on = -1;
    pulse_reset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < DEAD + SYNC_LAT + 3; i++) begin
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (!lockstep_ok()) begin
          failures++;
          $display("[TB] FAIL pulses_lockstep cyc=%0d got %s want %s", cyc, got_s(), want_s());
        end
      end
      if (p < 2) for (int i = 0; i < SYNC_LAT + 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (pulse_cnt !== 8'd3 || dump_on_gate !== 1'b1) begin
      failures++;
      $display("[TB] FAIL three_pulses got %s want on=1 cnt=3", got_s());
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    checks++;
    if ({dump_on_gate, dump_off_gate, fault, pulse_cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_on got %s want all zero", got_s());
    end
    for (int i = 1; i <= DEAD + SYNC_LAT + 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      if (dump_on_gate === 1'b1 && first_on < 0) first_on = i;
    end
    checks++;
    if (first_on !== DEAD + 1 + SYNC_LAT) begin
      failures++;
      $display("[TB] FAIL post_reset_latency got %0d want %0d", first_on, DEAD + 1 + SYNC_LAT);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int p = 0; p < 300; p++) begin
      for (int i = 0; i < DEAD + SYNC_LAT + 1; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < SYNC_LAT + 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (!lockstep_ok()) begin
        failures++;
        $display("[TB] FAIL saturation_lockstep pulse=%0d got %s want %s", p, got_s(), want_s());
      end
    end
    checks++;
    if (pulse_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL pulse_saturation got %0d want 255", pulse_cnt);
    end
  endtask

  task automatic test_over_drop();
    int first_low = -1;
    for (int i = 0; i < DEAD + SYNC_LAT + 2; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= SYNC_LAT + 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      if (dump_on_gate === 1'b0 && first_low < 0) first_low = i;
    end
    checks++;
    if (first_low !== 1 + SYNC_LAT || dump_off_gate !== 1'b0) begin
      failures++;
      $display("[TB] FAIL over_drop got first_low=%0d %s want %0d", first_low, got_s(), 1 + SYNC_LAT);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int b = 0; b < 150; b++) begin
      int kind = $urandom_range(0, 9);
      int len = $urandom_range(1, 30);
      bit on_v = (kind <= 3) || kind == 8;
      bit off_v = (kind >= 4 && kind <= 6) || kind == 8;
      bit ov_v = (kind != 7);
      for (int i = 0; i < len; i++) begin
        reset = ($urandom_range(0, 299) == 0);
        drive(on_v, off_v, ov_v, $urandom_range(0, 5) == 0);
        reset = 1'b0;
        checks++;
        if (!lockstep_ok()) begin
          failures++;
          $display("[TB] FAIL random_lockstep cyc=%0d got %s want %s", cyc, got_s(), want_s());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dead_time();
    test_switchover();
    test_fault_clear();
    test_watchdog();
    test_reset_mid_on();
    test_saturation();
    test_over_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dump_gate_driver.md
Name: dump_gate_driver

Overview:
- Downstream stage of the dump-sequence timer. Consumes its dumpon_str / dumpoff_str / over outputs and produces the two power-switch gate drives for the transmitter-coil energy dump.
- Guarantees the two gates are never high together and inserts a programmable dead time on every gate change.
- Enforces a maximum ON-gate width (watchdog) and latches a fault on illegal input combinations.
- Counts completed ON pulses for status readback.

Parameters:
- DEAD_CYC, 4, dead-time length in clkin cycles; legal range 1..255 (8-bit counter).
- MAX_ON, 1000, maximum consecutive cycles dump_on_gate may stay high; legal range 1..65535 (16-bit timer).

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dumpon_str  in  1  request ON gate; same clkin domain as this block.
- dumpoff_str  in  1  request OFF gate.
- over  in  1  sequence-enable from the upstream timer; 1 = sequence running, 0 = sequence finished.
- clr_fault  in  1  fault clear; level-sensitive, synchronous.
- dump_on_gate  out  1  ON switch drive.
- dump_off_gate  out  1  OFF switch drive.
- fault  out  1  latched fault flag.
- pulse_cnt  out  8  number of ON-state entries; saturates at 255.

Behaviour:
- One clock domain (clkin). reset is synchronous and active-high: when reset=1 at a rising edge, state <= IDLE, all counters <= 0, and dump_on_gate, dump_off_gate, fault and pulse_cnt all <= 0. Reset overrides everything, including mid-ON or FAULT.
- Request decode, combinational, each cycle:
  - REQ_ON = over & dumpon_str & ~dumpoff_str
  - REQ_OFF = over & dumpoff_str & ~dumpon_str
  - REQ_BAD = over & dumpon_str & dumpoff_str
  - REQ_IDLE = otherwise
- Outputs are registered and decoded from the state register (Moore):
  - dump_on_gate = 1 only in ON.
  - dump_off_gate = 1 only in OFF.
  - fault = 1 only in FAULT.
- States and transitions (evaluated each edge; REQ_BAD has highest priority in every state except FAULT):
  - IDLE: REQ_ON -> DT_ON, dead counter <= DEAD_CYC-1. REQ_OFF -> DT_OFF, same counter load. REQ_BAD -> FAULT.
  - DT_ON: counter decrements. At 0 with REQ_ON -> ON, on_timer <= 0, pulse_cnt++ (saturating). REQ_OFF -> DT_OFF, counter reloaded. REQ_IDLE -> IDLE.
  - ON: on_timer increments. REQ_OFF -> DT_OFF. REQ_IDLE -> IDLE. If on_timer == MAX_ON-1 and still REQ_ON -> FAULT, so the gate is high for exactly MAX_ON cycles.
  - DT_OFF: mirror of DT_ON, ending in OFF. No pulse count, no watchdog.
  - OFF: REQ_ON -> DT_ON. REQ_IDLE -> IDLE.
  - FAULT: exits to IDLE only when clr_fault=1 and REQ_IDLE in the same cycle; otherwise holds.
- Latency: a request first present in cycle n (from IDLE or the opposite gate) gives the new gate high in cycle n+1+DEAD_CYC. Gate deassertion on request removal takes one cycle.
- Invariant: dump_on_gate & dump_off_gate == 0 in every cycle, including reset and FAULT exit.
- over=0 forces REQ_IDLE, so both gates drop within 1 cycle.
- A request toggling during dead time restarts the dead counter; it never shortens the dead time.
- pulse_cnt holds at 255 (no wrap) until reset.

Optional Feature:
- Macro DUMP_INPUT_SYNC_EN.
- Defined: dumpon_str, dumpoff_str and over each pass through a 2-flop synchronizer (reset to 0) before request decode. All request-to-gate latencies grow by 2 cycles; the block is then safe to drive from an asynchronous source.
- Undefined: inputs are used directly, with the latencies stated above.

Test Plan:
1. DEAD_CYC=4, over=1, dumpon_str rises in cycle 10 -> dump_on_gate high from cycle 15; dump_off_gate 0 throughout; pulse_cnt=1 from cycle 15.
2. From ON, dumpon_str=0 and dumpoff_str=1 in cycle 30 -> dump_on_gate low in cycle 31, dump_off_gate high in cycle 35; never both high.
3. dumpon_str and dumpoff_str both 1 in cycle 50 -> fault=1 and both gates 0 from cycle 51. clr_fault=1 with strobes low in cycle 60 -> fault=0 in cycle 61; clr_fault with a strobe still high -> fault held.
4. MAX_ON=20, DEAD_CYC=4, dumpon_str held high 40 cycles -> dump_on_gate high exactly 20 cycles, then fault=1 and both gates 0.
5. reset=1 for one cycle while in ON with pulse_cnt=3 -> next cycle both gates 0, fault 0, pulse_cnt 0; a new request then needs the full DEAD_CYC again.
6. 300 ON pulses -> pulse_cnt saturates at 255. Separately, over falls to 0 while dumpon_str=1 -> dump_on_gate 0 the next cycle.
